// File: rtl/hd44780_pkg.sv
// Shared constants, opcode decode and address helpers for the HD44780 responder.
// DDRAM addresses live in two 40-byte line windows: 0x00-0x27 and 0x40-0x67.
package hd44780_pkg;

   localparam int         DDRAM_DEPTH  = 80;
   localparam logic [6:0] LINE1_END    = 7'h27;
   localparam logic [6:0] LINE2_START  = 7'h40;
   localparam logic [6:0] LINE2_END    = 7'h67;
   localparam logic [6:0] LINE2_OFFSET = LINE2_START - 7'(DDRAM_DEPTH / 2);
   localparam logic [7:0] FILL_CHAR    = 8'h20;
   localparam logic [2:0] FUNC_RESET   = 3'b100;

   localparam int ENTRY_ID_BIT = 1;
   localparam int SHIFT_RL_BIT = 2;
   localparam int SHIFT_SC_BIT = 3;

   typedef enum logic [3:0] {
      OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPLAY,
      OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
   } op_e;

   typedef enum logic [1:0] {ST_FILL, ST_IDLE, ST_EXEC, ST_BUSY} state_e;

   // The highest set bit of an instruction byte selects the command.
   function automatic op_e decode_op(input logic [7:0] d);
      op_e op;
      casez (d)
         8'b1???_????: op = OP_DDRAM;
         8'b01??_????: op = OP_CGRAM;
         8'b001?_????: op = OP_FUNC;
         8'b0001_????: op = OP_SHIFT;
         8'b0000_1???: op = OP_DISPLAY;
         8'b0000_01??: op = OP_ENTRY;
         8'b0000_001?: op = OP_HOME;
         8'b0000_0001: op = OP_CLEAR;
         default:      op = OP_NOP;
      endcase
      return op;
   endfunction

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] nxt;
      if (inc) begin
         if (ac == LINE1_END)      nxt = LINE2_START;
         else if (ac == LINE2_END) nxt = 7'h00;
         else                      nxt = ac + 7'd1;
      end else begin
         if (ac == LINE2_START)    nxt = LINE1_END;
         else if (ac == 7'h00)     nxt = LINE2_END;
         else                      nxt = ac - 7'd1;
      end
      return nxt;
   endfunction

   // Gap addresses snap to the start of the following line window.
   function automatic logic [6:0] norm_addr(input logic [6:0] a);
      logic [6:0] n;
      if (a > LINE1_END && a < LINE2_START) n = LINE2_START;
      else if (a > LINE2_END)               n = 7'h00;
      else                                  n = a;
      return n;
   endfunction

   function automatic logic [6:0] ac_to_idx(input logic [6:0] a);
      return (a < LINE2_START) ? a : a - LINE2_OFFSET;
   endfunction

endpackage

// File: rtl/hd44780_responder_if.sv
// HD44780 parallel bus: initiator drives data/rs/rw/en, responder returns read data.
interface hd44780_bus_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_dout;

   modport master (output lcd_data, lcd_rs, lcd_rw, lcd_en, input lcd_dout);
   modport slave  (input lcd_data, lcd_rs, lcd_rw, lcd_en, output lcd_dout);
endinterface

// File: rtl/hd44780_responder_ddram_80x8.sv
// 80x8 display RAM: one synchronous write port, registered read ports for the bus and the HPS.
module ddram_80x8
   import hd44780_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we_i,
   input  logic [6:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [6:0] bus_raddr_i,
   output logic [7:0] bus_rdata_o,
   input  logic [6:0] hps_raddr_i,
   output logic [7:0] hps_rdata_o
);

   logic [7:0] mem_q [DDRAM_DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_rdata_o <= '0;
         hps_rdata_o <= '0;
      end else begin
         bus_rdata_o <= mem_q[bus_raddr_i];
         hps_rdata_o <= mem_q[hps_raddr_i];
      end
   end

endmodule

// File: rtl/hd44780_responder.sv
// HD44780 responder: samples the LCD bus, decodes instructions/data and keeps a DDRAM image
// plus display state, answering bus reads and serving the image to the HPS.
module hd44780_responder
   import hd44780_pkg::*;
#(
   parameter int OP_CYCLES    = 2000,
   parameter int CLEAR_CYCLES = 76500
) (
   input  logic         clk,
   input  logic         rst,
   hd44780_bus_if.slave bus,
   input  logic [6:0]   rd_addr,
   output logic [7:0]   rd_char,
   output logic         busy,
   output logic [6:0]   cur_addr,
   output logic         inc_dir,
   output logic         disp_on,
   output logic         cursor_on,
   output logic         blink_on,
   output logic [2:0]   func_bits,
   output logic         err_busy,
   output logic [15:0]  wr_count
);

   localparam int CNT_MAX = (CLEAR_CYCLES > OP_CYCLES) ? CLEAR_CYCLES : OP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] OP_LOAD  = CNT_W'(OP_CYCLES);
   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             en_q, en2_q, rs_q, rw_q;
   logic [7:0]       data_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       fill_q, fill_d, ac_q, ac_d;
   logic             inc_q, inc_d, err_q, err_d, cg_q, cg_d;
   logic [2:0]       dcb_q, dcb_d, func_q, func_d;
   logic [15:0]      wrc_q, wrc_d;
   logic             cmd_rs_q, cmd_rs_d, cmd_rw_q, cmd_rw_d;
   logic [7:0]       cmd_data_q, cmd_data_d, dout_q, dout_d;
   logic             we, en_rise, en_fall;
   logic [6:0]       waddr;
   logic [7:0]       wdata, bus_rdata;

   assign en_rise = en_q & ~en2_q;
   assign en_fall = en2_q & ~en_q;
   assign busy    = (state_q == ST_FILL) || (state_q == ST_BUSY);

   always_comb begin
      state_d    = state_q;   cnt_d      = cnt_q;    fill_d   = fill_q;
      ac_d       = ac_q;      inc_d      = inc_q;    dcb_d    = dcb_q;
      func_d     = func_q;    err_d      = err_q;    wrc_d    = wrc_q;
      cg_d       = cg_q;      cmd_rs_d   = cmd_rs_q; cmd_rw_d = cmd_rw_q;
      cmd_data_d = cmd_data_q; dout_d    = dout_q;
      we         = 1'b0;      waddr      = fill_q;   wdata    = FILL_CHAR;

      if (en_rise && rw_q) dout_d = rs_q ? bus_rdata : {busy, ac_q};
      if (en_fall && !rw_q && state_q != ST_IDLE) err_d = 1'b1;

      case (state_q)
         ST_FILL: begin
            we     = 1'b1;
            fill_d = fill_q + 7'd1;
            if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
            if (fill_q == 7'(DDRAM_DEPTH - 1)) state_d = (cnt_q <= CNT_ONE) ? ST_IDLE : ST_BUSY;
         end
         ST_IDLE: begin
            // Status reads have no side effects; writes and data reads execute.
            if (en_fall && (!rw_q || rs_q)) begin
               cmd_rs_d   = rs_q;
               cmd_rw_d   = rw_q;
               cmd_data_d = data_q;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_BUSY;
            cnt_d   = OP_LOAD;
            if (!cmd_rs_q) begin
               case (decode_op(cmd_data_q))
                  OP_CLEAR: begin
                     state_d = ST_FILL;
                     fill_d  = '0;
                     cnt_d   = CLR_LOAD;
                     ac_d    = '0;
                     inc_d   = 1'b1;
                  end
                  OP_HOME:    ac_d   = '0;
                  OP_ENTRY:   inc_d  = cmd_data_q[ENTRY_ID_BIT];
                  OP_DISPLAY: dcb_d  = cmd_data_q[2:0];
                  OP_SHIFT:   if (!cmd_data_q[SHIFT_SC_BIT]) ac_d = ac_step(ac_q, cmd_data_q[SHIFT_RL_BIT]);
                  OP_FUNC:    func_d = cmd_data_q[4:2];
                  OP_CGRAM:   cg_d   = 1'b1;
                  OP_DDRAM: begin
                     ac_d = norm_addr(cmd_data_q[6:0]);
                     cg_d = 1'b0;
                  end
                  default: ;
               endcase
            end else if (!cmd_rw_q) begin
               if (!cg_q) begin
                  we    = 1'b1;
                  waddr = ac_to_idx(ac_q);
                  wdata = cmd_data_q;
                  wrc_d = wrc_q + 16'd1;
                  ac_d  = ac_step(ac_q, inc_q);
               end
            end else begin
               ac_d = ac_step(ac_q, inc_q);
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b0;  en2_q <= 1'b0;  rs_q <= 1'b0;  rw_q <= 1'b0;  data_q <= '0;
         state_q  <= ST_FILL;  cnt_q <= '0;  fill_q <= '0;  ac_q <= '0;  inc_q <= 1'b1;
         dcb_q    <= '0;  func_q <= FUNC_RESET;  err_q <= 1'b0;  wrc_q <= '0;  cg_q <= 1'b0;
         cmd_rs_q <= 1'b0;  cmd_rw_q <= 1'b0;  cmd_data_q <= '0;  dout_q <= '0;
      end else begin
         en_q     <= bus.lcd_en;  en2_q <= en_q;  rs_q <= bus.lcd_rs;  rw_q <= bus.lcd_rw;
         data_q   <= bus.lcd_data;
         state_q  <= state_d;  cnt_q <= cnt_d;  fill_q <= fill_d;  ac_q <= ac_d;  inc_q <= inc_d;
         dcb_q    <= dcb_d;  func_q <= func_d;  err_q <= err_d;  wrc_q <= wrc_d;  cg_q <= cg_d;
         cmd_rs_q <= cmd_rs_d;  cmd_rw_q <= cmd_rw_d;  cmd_data_q <= cmd_data_d;  dout_q <= dout_d;
      end
   end

   ddram_80x8 u_ddram (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .bus_raddr_i (ac_to_idx(ac_q)),
      .bus_rdata_o (bus_rdata),
      .hps_raddr_i (ac_to_idx(norm_addr(rd_addr))),
      .hps_rdata_o (rd_char)
   );

   assign bus.lcd_dout = dout_q;
   assign cur_addr     = ac_q;
   assign inc_dir      = inc_q;
   assign disp_on      = dcb_q[2];
   assign cursor_on    = dcb_q[1];
   assign blink_on     = dcb_q[0];
   assign func_bits    = func_q;
   assign err_busy     = err_q;
   assign wr_count     = wrc_q;

endmodule
